aes_key_expand: RTL and testbench



---
 rtl/aes_key_expand.sv | 170 +++++++++++++++++
 tb/tb_aes_key_expand.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: accepts one cipher key via valid/ready, generates
// round keys 0..10 at one per clock into an internal register file, and
// exposes a combinational indexed read port for the round controller.

// Forward AES S-box, purely combinational table lookup.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Table lookup.
  always_comb begin
    out_byte = SBOX_TABLE[in_byte];
  end

endmodule

module aes_key_expand #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  state_t       state;
  state_t       state_next;
  logic         load;
  logic         step;
  logic         last_step;

  logic [127:0] key_mem [11];
  logic [3:0]   ctr;
  logic [3:0]   prev_idx;
  logic [7:0]   rcon;

  logic [127:0] prev_key;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  temp_word;
  logic [31:0]  n0, n1, n2, n3;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    xtime = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last_step  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (key_valid) begin
          load       = 1'b1;
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (ctr == LAST_ROUND) begin
          last_step  = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign key_ready = (state != EXPAND);
  assign busy      = (state == EXPAND);

  // One key-schedule round: derive key[ctr] from key[ctr-1].
  always_comb begin
    prev_idx  = (ctr == 4'd0) ? 4'd0 : ctr - 4'd1;
    prev_key  = key_mem[prev_idx];
    w0        = prev_key[127:96];
    w1        = prev_key[95:64];
    w2        = prev_key[63:32];
    w3        = prev_key[31:0];
    rot_word  = {w3[23:0], w3[31:24]};
    temp_word = sub_word ^ {rcon, 24'h0};
    n0        = w0 ^ temp_word;
    n1        = w1 ^ n0;
    n2        = w2 ^ n1;
    n3        = w3 ^ n2;
  end

  aes_sbox u_sbox0 (.in_byte(rot_word[31:24]), .out_byte(sub_word[31:24]));
  aes_sbox u_sbox1 (.in_byte(rot_word[23:16]), .out_byte(sub_word[23:16]));
  aes_sbox u_sbox2 (.in_byte(rot_word[15:8]),  .out_byte(sub_word[15:8]));
  aes_sbox u_sbox3 (.in_byte(rot_word[7:0]),   .out_byte(sub_word[7:0]));

  // Key register file, round counter, rcon and completion flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 11; i++) begin
        key_mem[i] <= '0;
      end
      ctr        <= '0;
      rcon       <= 8'h01;
      keys_valid <= 1'b0;
    end else if (load) begin
      key_mem[0] <= key_in;
      ctr        <= 4'd1;
      rcon       <= 8'h01;
      keys_valid <= 1'b0;
    end else if (step) begin
      key_mem[ctr] <= {n0, n1, n2, n3};
      ctr          <= ctr + 4'd1;
      rcon         <= xtime(rcon);
      if (last_step) begin
        keys_valid <= 1'b1;
      end
    end
  end

  // Combinational read port; indices past the last round read as zero.
  always_comb begin
    rd_key = '0;
    if (rd_round <= LAST_ROUND) begin
      rd_key = key_mem[rd_round];
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 key-schedule vectors.
module tb_aes_key_expand;

  logic         clk;
  logic         reset_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;

  int unsigned errors;
  int unsigned checks;

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_C1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_R10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  aes_key_expand #(.NUM_ROUNDS(10)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rd_round   (rd_round),
    .rd_key     (rd_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a key for one edge; returns after that edge.
  task automatic load_key(input logic [127:0] k);
    key_in    = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    key_in    = '0;
  endtask

  task automatic read_key(input logic [3:0] r, output logic [127:0] k);
    rd_round = r;
    #1;
    k = rd_key;
  endtask

  task automatic test_reset();
    logic [127:0] k;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (key_ready !== 1'b1 || busy !== 1'b0 || keys_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ready=%b busy=%b kv=%b required 1 0 0", key_ready, busy, keys_valid);
    end
    for (int r = 0; r < 16; r++) begin
      read_key(4'(r), k);
      checks++;
      if (k !== 128'h0) begin
        errors++;
        $display("FAIL reset_rd_key[%0d]: got %h required 0", r, k);
      end
    end
  endtask

  task automatic test_fips_a1();
    int n;
    logic [127:0] k;
    load_key(KEY_A1);
    n = 0;
    while (busy === 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL a1_busy_cycles: got %0d required 10", n);
    end
    checks++;
    if (keys_valid !== 1'b1 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL a1_keys_valid: kv=%b ready=%b required 1 1", keys_valid, key_ready);
    end
    read_key(4'd0, k);
    checks++;
    if (k !== KEY_A1) begin
      errors++;
      $display("FAIL a1_round0: got %h required %h", k, KEY_A1);
    end
    read_key(4'd1, k);
    checks++;
    if (k !== A1_R1) begin
      errors++;
      $display("FAIL a1_round1: got %h required %h", k, A1_R1);
    end
    read_key(4'd10, k);
    checks++;
    if (k !== A1_R10) begin
      errors++;
      $display("FAIL a1_round10: got %h required %h", k, A1_R10);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [127:0] k;
    load_key(KEY_C1);
    checks++;
    if (keys_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drop: kv=%b busy=%b required 0 1", keys_valid, busy);
    end
    n = 0;
    while (keys_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL b2b_rise_cycles: got %0d required 10", n);
    end
    read_key(4'd10, k);
    checks++;
    if (k !== C1_R10) begin
      errors++;
      $display("FAIL b2b_round10: got %h required %h", k, C1_R10);
    end
  endtask

  task automatic test_key_during_busy();
    int n;
    logic [127:0] k;
    load_key(KEY_A1);
    tick();
    tick();
    tick();
    checks++;
    if (key_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready: got %b required 0", key_ready);
    end
    key_in    = '1;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    key_in    = '0;
    n = 0;
    while (keys_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL busy_remaining_cycles: got %0d required 6", n);
    end
    read_key(4'd0, k);
    checks++;
    if (k !== KEY_A1) begin
      errors++;
      $display("FAIL busy_round0: got %h required %h", k, KEY_A1);
    end
    read_key(4'd10, k);
    checks++;
    if (k !== A1_R10) begin
      errors++;
      $display("FAIL busy_round10: got %h required %h", k, A1_R10);
    end
  endtask

  task automatic test_reset_mid_expand();
    int n;
    logic [127:0] k;
    load_key(KEY_C1);
    for (int i = 0; i < 4; i++) tick();
    reset_n = 1'b0;
    tick();
    checks++;
    if (key_ready !== 1'b1 || busy !== 1'b0 || keys_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_flags: ready=%b busy=%b kv=%b required 1 0 0", key_ready, busy, keys_valid);
    end
    for (int r = 0; r < 11; r++) begin
      read_key(4'(r), k);
      checks++;
      if (k !== 128'h0) begin
        errors++;
        $display("FAIL midrst_rd_key[%0d]: got %h required 0", r, k);
      end
    end
    // Key offered while reset is held must not be taken.
    load_key(KEY_A1);
    reset_n = 1'b1;
    tick();
    read_key(4'd0, k);
    checks++;
    if (busy !== 1'b0 || k !== 128'h0) begin
      errors++;
      $display("FAIL rst_vs_key: busy=%b key0=%h required 0 0", busy, k);
    end
    load_key(KEY_A1);
    n = 0;
    while (keys_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL midrst_reload_cycles: got %0d required 10", n);
    end
    read_key(4'd1, k);
    checks++;
    if (k !== A1_R1) begin
      errors++;
      $display("FAIL midrst_round1: got %h required %h", k, A1_R1);
    end
    read_key(4'd10, k);
    checks++;
    if (k !== A1_R10) begin
      errors++;
      $display("FAIL midrst_round10: got %h required %h", k, A1_R10);
    end
  endtask

  task automatic test_out_of_range();
    logic [127:0] k;
    read_key(4'd11, k);
    checks++;
    if (k !== 128'h0) begin
      errors++;
      $display("FAIL oor_11: got %h required 0", k);
    end
    read_key(4'd15, k);
    checks++;
    if (k !== 128'h0) begin
      errors++;
      $display("FAIL oor_15: got %h required 0", k);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset_n   = 1'b0;
    key_in    = '0;
    key_valid = 1'b0;
    rd_round  = '0;
    test_reset();
    test_fips_a1();
    test_back_to_back();
    test_key_during_busy();
    test_reset_mid_expand();
    test_out_of_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
